// File: rtl/miriscv_dmem_pkg.sv
// Shared constants and access classification for the miriscv data memory responder.
package miriscv_dmem_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_RD,
    ACC_WR,
    ACC_TOHOST_RD,
    ACC_TOHOST_WR,
    ACC_ERR
  } acc_kind_e;

  // limit is the exclusive upper RAM bound, one bit wider so the range test cannot wrap.
  function automatic acc_kind_e classify_access(
    input logic                 req,
    input logic                 we,
    input logic [NUM_LANES-1:0] be,
    input logic [WORD_W-1:0]    addr,
    input logic [WORD_W-1:0]    base,
    input logic [WORD_W:0]      limit,
    input logic [WORD_W-1:0]    tohost
  );
    logic in_range;
    logic is_tohost;
    in_range  = ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
    is_tohost = (addr[WORD_W-1:2] == tohost[WORD_W-1:2]);
    if (!req)               return ACC_NONE;
    if (we && (be == '0))   return ACC_NONE;
    if (in_range)           return we ? ACC_WR : ACC_RD;
    if (is_tohost) begin
      if (!we)              return ACC_TOHOST_RD;
      return (be == '1) ? ACC_TOHOST_WR : ACC_ERR;
    end
    return ACC_ERR;
  endfunction

endpackage

// File: rtl/miriscv_dmem_bank.sv
// Word-organised storage with per-byte write enables and a registered read port.
module miriscv_dmem_bank
  import miriscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk_i,
  input  logic                 rd_en_i,
  input  logic [NUM_LANES-1:0] we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  output logic [WORD_W-1:0]    rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int unsigned n = 0; n < NUM_LANES; n++) begin
      if (we_i[n]) mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
    end
    if (rd_en_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/miriscv_data_mem.sv
// Data memory responder: RAM bank, sticky error flag and tohost register.
// Optional access counters are enabled with `define MIRISCV_DMEM_STATS_EN.
module miriscv_data_mem
  import miriscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        err_o,
  output logic        tohost_valid_o,
`ifdef MIRISCV_DMEM_STATS_EN
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
`endif
  output logic [31:0] tohost_data_o
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  acc_kind_e             kind;
  logic [AW-1:0]         idx;
  logic                  bank_rd;
  logic [NUM_LANES-1:0]  bank_we;
  logic [WORD_W-1:0]     bank_rdata;
  logic                  src_ram_q;
  logic [WORD_W-1:0]     aux_q;
  logic                  err_q;
  logic                  tohost_valid_q;
  logic [WORD_W-1:0]     tohost_data_q;

  assign kind = classify_access(data_req_i, data_we_i, data_be_i, data_addr_i,
                                BASE_ADDR, LIMIT, TOHOST_ADDR);
  assign idx  = AW'((data_addr_i - BASE_ADDR) >> 2);

  always_comb begin
    bank_rd = 1'b0;
    bank_we = '0;
    if (!arst_i) begin
      bank_rd = (kind == ACC_RD);
      bank_we = (kind == ACC_WR) ? data_be_i : '0;
    end
  end

  miriscv_dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk_i   (clk_i),
    .rd_en_i (bank_rd),
    .we_i    (bank_we),
    .addr_i  (idx),
    .wdata_i (data_wdata_i),
    .rdata_o (bank_rdata)
  );

  // The bank's read register holds on non-reads; non-RAM read results live in aux_q
  // and src_ram_q picks which one is presented.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      src_ram_q      <= 1'b0;
      aux_q          <= '0;
      err_q          <= 1'b0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
    end else begin
      unique case (kind)
        ACC_RD: src_ram_q <= 1'b1;
        ACC_TOHOST_RD: begin
          src_ram_q <= 1'b0;
          aux_q     <= tohost_data_q;
        end
        ACC_TOHOST_WR: begin
          if (!tohost_valid_q) begin
            tohost_valid_q <= 1'b1;
            tohost_data_q  <= data_wdata_i;
          end
        end
        ACC_ERR: begin
          err_q <= 1'b1;
          if (!data_we_i) begin
            src_ram_q <= 1'b0;
            aux_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_rdata_o   = src_ram_q ? bank_rdata : aux_q;
  assign err_o          = err_q;
  assign tohost_valid_o = tohost_valid_q;
  assign tohost_data_o  = tohost_data_q;

`ifdef MIRISCV_DMEM_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if ((kind == ACC_RD) && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if ((kind == ACC_WR) && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_miriscv_data_mem.sv
// Directed self-checking bench for miriscv_data_mem (default parameters).
module tb_miriscv_data_mem;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        err_o;
  logic        tohost_valid_o;
  logic [31:0] tohost_data_o;
`ifdef MIRISCV_DMEM_STATS_EN
  logic [31:0] rd_cnt_o;
  logic [31:0] wr_cnt_o;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk_i = ~clk_i;

  miriscv_data_mem #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .TOHOST_ADDR (32'h8000_0000)
  ) dut (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_rdata_o   (data_rdata_o),
    .err_o          (err_o),
    .tohost_valid_o (tohost_valid_o),
`ifdef MIRISCV_DMEM_STATS_EN
    .rd_cnt_o       (rd_cnt_o),
    .wr_cnt_o       (wr_cnt_o),
`endif
    .tohost_data_o  (tohost_data_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One access per cycle: drive at the falling edge, observe 1 time unit after the rising edge.
  task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(negedge clk_i);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    @(negedge clk_i);
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1;
    check("rst_rdata", data_rdata_o, 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_tohost_valid", 32'(tohost_valid_o), 32'h0);
    check("rst_tohost_data", tohost_data_o, 32'h0);
    @(negedge clk_i);
    arst_i = 1'b0;

    access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    access(1'b0, 4'h0, 32'h10, 32'h0);
    check("full_word_rd", data_rdata_o, 32'hDEADBEEF);
    check("full_word_err", 32'(err_o), 32'h0);

    access(1'b1, 4'b0010, 32'h10, 32'h0000_AA00);
    access(1'b0, 4'h0, 32'h10, 32'h0);
    check("lane1_rd", data_rdata_o, 32'hDEADAAEF);
    access(1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
    access(1'b0, 4'hF, 32'h10, 32'h0);
    check("be0_rd", data_rdata_o, 32'hDEADAAEF);
    check("be0_err", 32'(err_o), 32'h0);

    idle();
    check("idle_hold", data_rdata_o, 32'hDEADAAEF);
    access(1'b1, 4'hF, 32'h14, 32'h1122_3344);
    check("write_hold", data_rdata_o, 32'hDEADAAEF);
    access(1'b0, 4'h0, 32'h14, 32'h0);
    check("b2b_rd0", data_rdata_o, 32'h1122_3344);
    access(1'b0, 4'h0, 32'h13, 32'h0);
    check("b2b_rd1_lowbits", data_rdata_o, 32'hDEADAAEF);

    access(1'b1, 4'hF, 32'h20, 32'hCAFE_F00D);
    access(1'b0, 4'h0, 32'h20, 32'h0);
    check("raw_rd", data_rdata_o, 32'hCAFE_F00D);

    access(1'b1, 4'hF, 32'h8000_0000, 32'h1);
    check("tohost_valid", 32'(tohost_valid_o), 32'h1);
    check("tohost_data", tohost_data_o, 32'h1);
    access(1'b1, 4'hF, 32'h8000_0000, 32'h5);
    check("tohost_first_wins", tohost_data_o, 32'h1);
    access(1'b0, 4'h0, 32'h8000_0000, 32'h0);
    check("tohost_rd", data_rdata_o, 32'h1);
    check("tohost_rd_err", 32'(err_o), 32'h0);
    access(1'b1, 4'b0011, 32'h8000_0000, 32'h9);
    check("tohost_partial_err", 32'(err_o), 32'h1);
    check("tohost_partial_data", tohost_data_o, 32'h1);

    // Reset lands in the middle of a write cycle to 0x20.
    @(negedge clk_i);
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h20;
    data_wdata_i = 32'h1234_5678;
    #2;
    arst_i = 1'b1;
    #1;
    check("arst_rdata", data_rdata_o, 32'h0);
    check("arst_err", 32'(err_o), 32'h0);
    check("arst_tohost_valid", 32'(tohost_valid_o), 32'h0);
    check("arst_tohost_data", tohost_data_o, 32'h0);
    @(posedge clk_i);
    #1;
    check("arst_edge_rdata", data_rdata_o, 32'h0);
    @(negedge clk_i);
    arst_i     = 1'b0;
    data_req_i = 1'b0;

    access(1'b0, 4'h0, 32'h20, 32'h0);
    check("arst_write_dropped", data_rdata_o, 32'hCAFE_F00D);
    access(1'b1, 4'hF, 32'hFFC, 32'hA5A5_A5A5);
    access(1'b0, 4'h0, 32'hFFC, 32'h0);
    check("last_word_rd", data_rdata_o, 32'hA5A5_A5A5);
    check("last_word_err", 32'(err_o), 32'h0);
    access(1'b1, 4'b0001, 32'h24, 32'h0000_0077);
    access(1'b0, 4'h0, 32'h1000, 32'h0);
    check("oor_rdata", data_rdata_o, 32'h0);
    check("oor_err", 32'(err_o), 32'h1);
    access(1'b0, 4'h0, 32'h10, 32'h0);
    check("err_sticky_rd", data_rdata_o, 32'hDEADAAEF);
    check("err_sticky", 32'(err_o), 32'h1);
`ifdef MIRISCV_DMEM_STATS_EN
    check("rd_cnt", rd_cnt_o, 32'd3);
    check("wr_cnt", wr_cnt_o, 32'd2);
`endif
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
